// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//
// Shared sizing for the FFT line unpacker and its line buffer.
//   SIZE             : sample width in bits
//   SAMPLES          : samples per FFT frame
//   LINE_SIZE        : host line width in bits
//   SAMPLES_PER_LINE : samples packed into one host line (32 by default)
//   LINES_PER_FRAME  : host lines that make one frame (64 by default)
//
// Modules take these as parameter defaults through scoped references
// (fft_pkg::SIZE, ...) so that their own SIZE/SAMPLES/LINE_SIZE parameters
// never collide with the package names.
// ---------------------------------------------------------------------------
package fft_pkg;

   localparam int SIZE             = 16;
   localparam int SAMPLES          = 2048;
   localparam int LINE_SIZE        = 512;
   localparam int SAMPLES_PER_LINE = LINE_SIZE / SIZE;
   localparam int LINES_PER_FRAME  = SAMPLES / SAMPLES_PER_LINE;

endpackage : fft_pkg

// File: rtl/fft_line_buffer.sv
// ---------------------------------------------------------------------------
// fft_line_buffer
//
// Two-slot (ping-pong) line store. Each slot has a registered full flag;
// wr_ptr selects the slot the next line is written into, rd_ptr the slot
// currently being drained. Both pointers simply toggle between the slots.
//
// Handshake semantics (both sides): a transfer happens on the rising clock
// edge where the request (wr_en / rd_done) is high and the slot it targets
// is in the right state (empty for a write, full for a read release).
// Requests against a slot in the wrong state are ignored.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset (clears flags,
//                 pointers and slot contents)
//   clear       : synchronous flush of flags and pointers; wins over writes
//                 and releases in the same cycle
//   wr_en       : write wr_data into slot[wr_ptr] this edge
//   wr_data     : line to store
//   wr_ready    : slot[wr_ptr] is empty (purely from registers)
//   rd_done     : the last sample of slot[rd_ptr] is consumed this edge
//   rd_valid    : slot[rd_ptr] holds a line
//   rd_data     : contents of slot[rd_ptr]
// ---------------------------------------------------------------------------
module fft_line_buffer #(
   parameter int LINE_SIZE = fft_pkg::LINE_SIZE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 wr_en,
   input  logic [LINE_SIZE-1:0] wr_data,
   output logic                 wr_ready,
   input  logic                 rd_done,
   output logic                 rd_valid,
   output logic [LINE_SIZE-1:0] rd_data
);

   logic [LINE_SIZE-1:0] slot0_q, slot0_d;
   logic [LINE_SIZE-1:0] slot1_q, slot1_d;
   logic [1:0]           full_q, full_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic                 wr_fire;
   logic                 rd_fire;

   // Outputs come straight from flops plus a 2:1 select on the pointer, so
   // there is no combinational path from any input to wr_ready / rd_valid.
   assign wr_ready = ~full_q[wr_ptr_q];
   assign rd_valid = full_q[rd_ptr_q];
   assign rd_data  = rd_ptr_q ? slot1_q : slot0_q;

   // A write needs an empty target, a release needs a full one. When the
   // pointers are equal only one of the two can be true, so a write and a
   // release in the same cycle always hit different slots.
   assign wr_fire = wr_en & ~full_q[wr_ptr_q];
   assign rd_fire = rd_done & full_q[rd_ptr_q];

   always_comb begin
      slot0_d  = slot0_q;
      slot1_d  = slot1_q;
      full_d   = full_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;

      if (clear) begin
         // Slot contents are left alone; with every flag clear they are
         // unreachable until overwritten.
         full_d   = 2'b00;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (wr_fire) begin
            if (wr_ptr_q) begin
               slot1_d = wr_data;
            end else begin
               slot0_d = wr_data;
            end
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
         end
         // A slot released here only shows as ready after this edge, so
         // it cannot be refilled before the following edge.
         if (rd_fire) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0_q  <= '0;
         slot1_q  <= '0;
         full_q   <= 2'b00;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         slot0_q  <= slot0_d;
         slot1_q  <= slot1_d;
         full_q   <= full_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule : fft_line_buffer

// File: rtl/fft_line_unpacker.sv
// ---------------------------------------------------------------------------
// fft_line_unpacker
//
// Turns wide host lines (LINE_SIZE bits, SAMPLES_PER_LINE packed samples,
// sample k at bits [SIZE*k +: SIZE]) into a one-sample-per-cycle stream for
// an FFT core, tagging each sample with its position in the frame.
//
// Handshake semantics (both interfaces): a transfer happens on the rising
// clock edge where valid and ready are both high. The producer holds its
// payload stable while valid is high and ready is low. line_ready and
// sample_valid are computed from registers only.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : synchronous flush of buffers and counters, highest priority
//   line_valid   : upstream offers line_data
//   line_data    : packed samples
//   line_ready   : a line slot is free
//   sample_valid : sample_data / sample_index / sample_last are valid
//   sample_ready : downstream takes the sample
//   sample_data  : current sample
//   sample_index : position in frame, 0..SAMPLES-1
//   sample_last  : sample_valid and sample_index == SAMPLES-1
//   frame_done   : one-cycle pulse after the handshake of the last sample
//
// Latency: a line accepted at edge t presents sample 0 in the cycle after t.
// With upstream keeping the spare slot filled, the stream has no bubbles.
// ---------------------------------------------------------------------------
module fft_line_unpacker #(
   parameter int SIZE      = fft_pkg::SIZE,
   parameter int SAMPLES   = fft_pkg::SAMPLES,
   parameter int LINE_SIZE = fft_pkg::LINE_SIZE
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       line_valid,
   input  logic [LINE_SIZE-1:0]       line_data,
   output logic                       line_ready,
   output logic                       sample_valid,
   input  logic                       sample_ready,
   output logic [SIZE-1:0]            sample_data,
   output logic [$clog2(SAMPLES)-1:0] sample_index,
   output logic                       sample_last,
   output logic                       frame_done
);

   localparam int SPL   = LINE_SIZE / SIZE;
   localparam int SUB_W = (SPL > 1) ? $clog2(SPL) : 1;
   localparam int IDX_W = $clog2(SAMPLES);

   localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SPL - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SAMPLES - 1);

   logic [SUB_W-1:0]     sub_q, sub_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 frame_done_q, frame_done_d;

   logic                 buf_wr_ready;
   logic                 buf_rd_valid;
   logic [LINE_SIZE-1:0] buf_rd_data;
   logic                 line_fire;
   logic                 sample_fire;
   logic                 line_drained;
   logic                 at_last;

   // clear suppresses both handshakes so that nothing is stored or counted
   // in the flush cycle.
   assign line_fire    = line_valid & buf_wr_ready & ~clear;
   assign sample_fire  = buf_rd_valid & sample_ready & ~clear;
   assign line_drained = sample_fire & (sub_q == SUB_MAX);
   assign at_last      = (idx_q == IDX_MAX);

   fft_line_buffer #(
      .LINE_SIZE (LINE_SIZE)
   ) u_line_buffer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .wr_en    (line_fire),
      .wr_data  (line_data),
      .wr_ready (buf_wr_ready),
      .rd_done  (line_drained),
      .rd_valid (buf_rd_valid),
      .rd_data  (buf_rd_data)
   );

   assign line_ready   = buf_wr_ready;
   assign sample_valid = buf_rd_valid;
   // Field select by the sub counter; both sub and the slot only move on a
   // sample handshake, so the payload holds while the FFT stalls.
   assign sample_data  = buf_rd_data[int'(sub_q) * SIZE +: SIZE];
   assign sample_index = idx_q;
   assign sample_last  = buf_rd_valid & at_last;
   assign frame_done   = frame_done_q;

   always_comb begin
      sub_d        = sub_q;
      idx_d        = idx_q;
      frame_done_d = 1'b0;

      if (clear) begin
         sub_d = '0;
         idx_d = '0;
      end else if (sample_fire) begin
         // sub wraps with the slot release handled in the line buffer.
         sub_d = (sub_q == SUB_MAX) ? '0 : sub_q + 1'b1;
         // Explicit wrap keeps non-power-of-two frame lengths correct.
         idx_d = at_last ? '0 : idx_q + 1'b1;
         frame_done_d = at_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_q        <= '0;
         idx_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         sub_q        <= sub_d;
         idx_q        <= idx_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule : fft_line_unpacker

// File: tb/tb_fft_line_unpacker.sv
// ---------------------------------------------------------------------------
// tb_fft_line_unpacker
//
// Directed bench for fft_line_unpacker. Inputs change on the falling edge,
// outputs are sampled on the falling edge, so every rising edge sees stable
// inputs. A scoreboard queue holds {frame index, sample value} for every
// sample of every line the bench saw accepted; each cycle with sample_valid
// high is compared against its head, and a handshake pops it.
// ---------------------------------------------------------------------------
module tb_fft_line_unpacker;

   localparam int SIZE      = fft_pkg::SIZE;
   localparam int SAMPLES   = fft_pkg::SAMPLES;
   localparam int LINE_SIZE = fft_pkg::LINE_SIZE;
   localparam int SPL       = fft_pkg::SAMPLES_PER_LINE;
   localparam int LPF       = fft_pkg::LINES_PER_FRAME;
   localparam int IW        = $clog2(SAMPLES);

   // ---------------- clock / reset / DUT ----------------
   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 clear;
   logic                 line_valid;
   logic [LINE_SIZE-1:0] line_data;
   logic                 line_ready;
   logic                 sample_valid;
   logic                 sample_ready;
   logic [SIZE-1:0]      sample_data;
   logic [IW-1:0]        sample_index;
   logic                 sample_last;
   logic                 frame_done;

   always #5 clk = ~clk;

   fft_line_unpacker #(
      .SIZE      (SIZE),
      .SAMPLES   (SAMPLES),
      .LINE_SIZE (LINE_SIZE)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .line_valid   (line_valid),
      .line_data    (line_data),
      .line_ready   (line_ready),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_data  (sample_data),
      .sample_index (sample_index),
      .sample_last  (sample_last),
      .frame_done   (frame_done)
   );

   // ---------------- scoreboard state ----------------
   logic [IW+SIZE-1:0] exp_q[$];
   logic [IW-1:0]      exp_idx;
   logic [SIZE-1:0]    cur_base;
   bit                 fd_exp;
   int                 n_checks = 0;
   int                 n_err    = 0;
   int                 tick_no  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_idx = '0;
      fd_exp  = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   // Line whose sample k holds base+k.
   task automatic set_line(input logic [SIZE-1:0] base);
      cur_base = base;
      for (int k = 0; k < SPL; k++) begin
         line_data[k*SIZE +: SIZE] = base + SIZE'(k);
      end
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_line_ready"},   line_ready,   1);
      check({pfx, "_sample_valid"}, sample_valid, 0);
      check({pfx, "_sample_last"},  sample_last,  0);
      check({pfx, "_frame_done"},   frame_done,   0);
      check({pfx, "_sample_data"},  sample_data,  0);
      check({pfx, "_sample_index"}, sample_index, 0);
   endtask

   task automatic do_reset(input string pfx);
      rst_n        = 1'b0;
      clear        = 1'b0;
      line_valid   = 1'b0;
      sample_ready = 1'b0;
      #1;
      check_reset_vals(pfx);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // One cycle at the falling edge: compare outputs with the model, predict
   // which handshakes the next rising edge performs, then advance.
   task automatic tick(output bit acc, output bit hs);
      logic [IW+SIZE-1:0] e;
      acc = 1'b0;
      hs  = 1'b0;
      check("frame_done", frame_done, fd_exp);
      fd_exp = 1'b0;
      if (clear) begin
         model_reset();
      end else begin
         if (sample_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_sample", sample_valid, 0);
            end else begin
               e = exp_q[0];
               check("sample_data",  sample_data,  e[SIZE-1:0]);
               check("sample_index", sample_index, e[IW+SIZE-1:SIZE]);
               check("sample_last",  sample_last,  e[IW+SIZE-1:SIZE] == IW'(SAMPLES-1));
               if (sample_ready) begin
                  hs = 1'b1;
                  void'(exp_q.pop_front());
                  fd_exp = (e[IW+SIZE-1:SIZE] == IW'(SAMPLES-1));
               end
            end
         end else begin
            check("sample_last_idle", sample_last, 0);
         end
         if (line_valid && line_ready) begin
            acc = 1'b1;
            for (int k = 0; k < SPL; k++) begin
               exp_q.push_back({exp_idx, cur_base + SIZE'(k)});
               exp_idx = exp_idx + 1'b1;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      tick_no++;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      bit acc, hs, started;
      int lines, cnt, gaps, fd_cnt, free_tick, acc_tick;

      line_data = '0;
      cur_base  = '0;
      exp_idx   = '0;
      fd_exp    = 1'b0;

      // Reset values
      do_reset("rst0");

      // One line, sample k = k+1, sample_ready high
      sample_ready = 1'b1;
      set_line(16'd1);
      line_valid = 1'b1;
      tick(acc, hs);
      check("t1_accept", acc, 1);
      line_valid = 1'b0;
      check("t1_latency_valid", sample_valid, 1);
      check("t1_first_data", sample_data, 1);
      for (int i = 0; i < SPL; i++) begin
         check("t1_line_ready", line_ready, 1);
         tick(acc, hs);
         check("t1_handshake", hs, 1);
      end
      check("t1_drained", exp_q.size(), 0);
      check("t1_idle_valid", sample_valid, 0);

      // 64 back-to-back lines: one full frame without gaps
      do_reset("rst1");
      sample_ready = 1'b1;
      lines = 0; cnt = 0; gaps = 0; fd_cnt = 0; started = 1'b0;
      for (int c = 0; c < SAMPLES + 60; c++) begin
         line_valid = (lines < LPF);
         set_line(SIZE'(lines * SPL));
         if (started && cnt < SAMPLES && !sample_valid) gaps++;
         if (sample_valid) started = 1'b1;
         if (frame_done) fd_cnt++;
         tick(acc, hs);
         if (acc) lines++;
         if (hs) cnt++;
      end
      line_valid = 1'b0;
      check("t2_lines", lines, LPF);
      check("t2_samples", cnt, SAMPLES);
      check("t2_gaps", gaps, 0);
      check("t2_frame_done_count", fd_cnt, 1);
      check("t2_drained", exp_q.size(), 0);

      // Backpressure: two lines fill both slots, the third stalls
      do_reset("rst2");
      sample_ready = 1'b0;
      line_valid   = 1'b1;
      set_line(16'd100);
      tick(acc, hs);
      check("t3_accept1", acc, 1);
      set_line(16'd200);
      tick(acc, hs);
      check("t3_accept2", acc, 1);
      check("t3_ready_low", line_ready, 0);
      set_line(16'd300);
      for (int i = 0; i < 5; i++) begin
         tick(acc, hs);
         check("t3_stalled", acc, 0);
      end
      check("t3_hold_data", sample_data, 100);
      check("t3_hold_index", sample_index, 0);
      sample_ready = 1'b1;
      free_tick = -1; acc_tick = -1;
      for (int c = 0; c < 3 * SPL + 10; c++) begin
         if (free_tick < 0 && exp_q.size() > 0 && exp_q[0][SIZE+4:SIZE] == 5'd31) free_tick = tick_no;
         if (acc_tick < 0) begin
            tick(acc, hs);
            if (acc) begin
               acc_tick   = tick_no - 1;
               line_valid = 1'b0;
            end
         end else begin
            tick(acc, hs);
         end
      end
      check("t3_refill_after_free", acc_tick, free_tick + 1);
      check("t3_drained", exp_q.size(), 0);

      // Random sample_ready over three frames
      do_reset("rst3");
      lines = 0; cnt = 0; fd_cnt = 0;
      for (int c = 0; c < 20000 && cnt < 3 * SAMPLES; c++) begin
         line_valid = (lines < 3 * LPF);
         set_line(SIZE'(lines * SPL));
         sample_ready = ($urandom_range(0, 1) == 1);
         if (frame_done) fd_cnt++;
         tick(acc, hs);
         if (acc) lines++;
         if (hs) cnt++;
      end
      line_valid   = 1'b0;
      sample_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (frame_done) fd_cnt++;
         tick(acc, hs);
      end
      check("t4_samples", cnt, 3 * SAMPLES);
      check("t4_frame_done_count", fd_cnt, 3);
      check("t4_drained", exp_q.size(), 0);

      // clear at sample 700
      do_reset("rst4");
      sample_ready = 1'b1;
      lines = 0; cnt = 0;
      for (int c = 0; c < 800 && cnt < 700; c++) begin
         line_valid = 1'b1;
         set_line(SIZE'(lines * SPL));
         tick(acc, hs);
         if (acc) lines++;
         if (hs) cnt++;
      end
      check("t5_at_700", sample_index, 700);
      clear = 1'b1;
      tick(acc, hs);
      clear      = 1'b0;
      line_valid = 1'b0;
      check("t5_valid_low", sample_valid, 0);
      check("t5_line_ready", line_ready, 1);
      check("t5_index_zero", sample_index, 0);
      set_line(16'h5000);
      line_valid = 1'b1;
      tick(acc, hs);
      check("t5_accept", acc, 1);
      line_valid = 1'b0;
      for (int i = 0; i < SPL + 2; i++) tick(acc, hs);
      check("t5_drained", exp_q.size(), 0);

      // Asynchronous reset mid-line
      sample_ready = 1'b1;
      set_line(16'h7000);
      line_valid = 1'b1;
      tick(acc, hs);
      line_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick(acc, hs);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("t6_async");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 40; i++) tick(acc, hs);
      check("t6_no_stale", sample_valid, 0);
      set_line(16'h0100);
      line_valid = 1'b1;
      tick(acc, hs);
      check("t6_accept", acc, 1);
      line_valid = 1'b0;
      for (int i = 0; i < SPL + 2; i++) tick(acc, hs);
      check("t6_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_fft_line_unpacker
